// File: rtl/rgb2ycbcr_package.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | rgb2ycbcr_package -- pixel, YUYV pair types and stream geometry constants
// | Revision: 1.0
// +-----------------------------------------------------------------------------
package rgb2ycbcr_package;

  localparam int unsigned CHANNEL_WIDTH   = 8;
  localparam int unsigned NB_CHANNELS     = 3;
  localparam int unsigned NB_PAIRS        = 3;
  localparam int unsigned NB_PAIRS_PER_IN = 2;
  localparam int unsigned NB_BUF          = 4;

  // Y sits in the LSBs of each packed pixel.
  typedef struct packed {
    logic [CHANNEL_WIDTH-1:0] cr;
    logic [CHANNEL_WIDTH-1:0] cb;
    logic [CHANNEL_WIDTH-1:0] y;
  } ycbcr_struct;

  // LSB first: y0, cb, y1, cr.
  typedef struct packed {
    logic [CHANNEL_WIDTH-1:0] cr;
    logic [CHANNEL_WIDTH-1:0] y1;
    logic [CHANNEL_WIDTH-1:0] cb;
    logic [CHANNEL_WIDTH-1:0] y0;
  } yuyv_pair_struct;

endpackage
`default_nettype wire

// File: rtl/hwpe_stream_intf_stream.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | hwpe_stream_intf_stream -- valid/ready stream bundle with data and strobe
// | Revision: 1.0
// +-----------------------------------------------------------------------------
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface
`default_nettype wire

// File: rtl/ycbcr_pair_avg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | ycbcr_pair_avg -- two YCbCr pixels to one YUYV pair (chroma averaged)
// | Macro HWPE_YCBCR422_ROUND_EN selects round-half-up instead of truncation.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module ycbcr_pair_avg
  import rgb2ycbcr_package::*;
(
  input  ycbcr_struct     pix0_i,
  input  ycbcr_struct     pix1_i,
  output yuyv_pair_struct pair_o
);

`ifdef HWPE_YCBCR422_ROUND_EN
  localparam logic [CHANNEL_WIDTH:0] ROUND_ADD = (CHANNEL_WIDTH+1)'(1);
`else
  localparam logic [CHANNEL_WIDTH:0] ROUND_ADD = '0;
`endif

  // One extra bit keeps the sum of two full-scale channels plus rounding exact.
  logic [CHANNEL_WIDTH:0] cb_sum;
  logic [CHANNEL_WIDTH:0] cr_sum;

  always_comb begin
    cb_sum    = {1'b0, pix0_i.cb} + {1'b0, pix1_i.cb} + ROUND_ADD;
    cr_sum    = {1'b0, pix0_i.cr} + {1'b0, pix1_i.cr} + ROUND_ADD;
    pair_o.y0 = pix0_i.y;
    pair_o.cb = CHANNEL_WIDTH'(cb_sum >> 1);
    pair_o.y1 = pix1_i.y;
    pair_o.cr = CHANNEL_WIDTH'(cr_sum >> 1);
  end

endmodule
`default_nettype wire

// File: rtl/hwpe_ycbcr422_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | hwpe_ycbcr422_packer -- 4 YCbCr pixels/beat in, 3 YUYV pairs/beat out
// | Macro HWPE_YCBCR422_ROUND_EN (in ycbcr_pair_avg) selects rounded chroma.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module hwpe_ycbcr422_packer
  import rgb2ycbcr_package::*;
#(
  parameter int unsigned STREAM_WIDTH = 96
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  input logic                    clear_i,
  hwpe_stream_intf_stream.sink   ycbcr,
  hwpe_stream_intf_stream.source yuyv
);

  localparam int unsigned PIX_WIDTH = CHANNEL_WIDTH * NB_CHANNELS;
  localparam int unsigned NB_DATA   = STREAM_WIDTH / PIX_WIDTH;

  if (STREAM_WIDTH != 12 * CHANNEL_WIDTH) begin : g_width_check
    $error("hwpe_ycbcr422_packer: STREAM_WIDTH must equal 12*CHANNEL_WIDTH");
  end

  ycbcr_struct     pix      [NB_DATA];
  yuyv_pair_struct pair_new [NB_PAIRS_PER_IN];
  yuyv_pair_struct pair_q   [NB_BUF];
  yuyv_pair_struct pair_d   [NB_BUF];
  logic [2:0]      count_q;
  logic [2:0]      count_d;
  logic [2:0]      remain;
  logic            out_valid;
  logic            in_ready;
  logic            in_fire;
  logic            out_fire;

  for (genvar i = 0; i < NB_DATA; i++) begin : g_unpack
    assign pix[i] = ycbcr.data[i*PIX_WIDTH +: PIX_WIDTH];
  end

  for (genvar k = 0; k < NB_PAIRS_PER_IN; k++) begin : g_pair
    ycbcr_pair_avg u_avg (
      .pix0_i (pix[2*k]),
      .pix1_i (pix[2*k+1]),
      .pair_o (pair_new[k])
    );
  end

  // Handshake signals depend only on the registered count and downstream ready.
  assign out_valid   = (count_q >= 3'(NB_PAIRS));
  assign in_ready    = (count_q <= 3'(NB_PAIRS - 1)) | yuyv.ready;
  assign in_fire     = ycbcr.valid & in_ready;
  assign out_fire    = out_valid & yuyv.ready;

  assign ycbcr.ready = in_ready;
  assign yuyv.valid  = out_valid;
  assign yuyv.data   = {pair_q[2], pair_q[1], pair_q[0]};
  assign yuyv.strb   = '1;

  // Entry 0 is always the oldest pair; a pop moves the single survivor down.
  always_comb begin
    pair_d = pair_q;
    remain = count_q;
    if (out_fire) begin
      remain    = count_q - 3'(NB_PAIRS);
      pair_d[0] = pair_q[NB_BUF-1];
      for (int i = 1; i < NB_BUF; i++) begin
        pair_d[i] = '0;
      end
    end
    if (in_fire) begin
      for (int i = 0; i < NB_BUF; i++) begin
        if (3'(i) == remain)        pair_d[i] = pair_new[0];
        if (3'(i) == remain + 3'd1) pair_d[i] = pair_new[1];
      end
    end
    count_d = remain + (in_fire ? 3'(NB_PAIRS_PER_IN) : 3'd0);
    if (clear_i) begin
      count_d = '0;
      for (int i = 0; i < NB_BUF; i++) begin
        pair_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      pair_q  <= '{default: '0};
    end else begin
      count_q <= count_d;
      pair_q  <= pair_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hwpe_ycbcr422_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_hwpe_ycbcr422_packer -- directed vectors and scoreboard for the packer
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_hwpe_ycbcr422_packer;

`ifdef HWPE_YCBCR422_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic clk_i   = 1'b0;
  logic rst_ni  = 1'b1;
  logic clear_i = 1'b0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(96)) ycbcr_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(96)) yuyv_if ();

  hwpe_ycbcr422_packer #(.STREAM_WIDTH(96)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .ycbcr   (ycbcr_if),
    .yuyv    (yuyv_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [95:0] data;
    logic [31:0] e0_t;
    logic [31:0] e1_t;
    logic [31:0] e0_r;
    logic [31:0] e1_r;
  } vec_t;

  vec_t        tbl [4];
  logic [31:0] exp_q [$];
  logic [31:0] pend0, pend1;
  logic        in_f, out_f;
  logic        stream_phase = 1'b0;
  int          total = 0;
  int          bad   = 0;
  int          n_out = 0;
  int          rdy_drop = 0;

  function automatic logic [23:0] px(input int y, input int cb, input int cr);
    return {8'(cr), 8'(cb), 8'(y)};
  endfunction

  function automatic logic [31:0] pw(input int y0, input int cb, input int y1, input int cr);
    return {8'(cr), 8'(y1), 8'(cb), 8'(y0)};
  endfunction

  function automatic logic [31:0] model_pair(input logic [23:0] a, input logic [23:0] b);
    int cb, cr;
    cb = (int'(a[15:8]) + int'(b[15:8]) + RND) / 2;
    cr = (int'(a[23:16]) + int'(b[23:16]) + RND) / 2;
    return pw(int'(a[7:0]), cb, int'(b[7:0]), cr);
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    #1;
    in_f  = ycbcr_if.valid & ycbcr_if.ready;
    out_f = yuyv_if.valid & yuyv_if.ready;
    chk("valid", 96'(yuyv_if.valid), 96'(exp_q.size() >= 3));
    chk("ready", 96'(ycbcr_if.ready), 96'((exp_q.size() <= 2) | yuyv_if.ready));
    if (stream_phase && !ycbcr_if.ready) rdy_drop++;
    if (clear_i) begin
      exp_q.delete();
    end else begin
      if (out_f) begin
        n_out++;
        if (exp_q.size() >= 3) begin
          chk("out_beat", yuyv_if.data, {exp_q[2], exp_q[1], exp_q[0]});
          void'(exp_q.pop_front());
          void'(exp_q.pop_front());
          void'(exp_q.pop_front());
        end
      end
      if (in_f) begin
        exp_q.push_back(pend0);
        exp_q.push_back(pend1);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic send(input logic [95:0] d, input logic [31:0] e0, input logic [31:0] e1);
    ycbcr_if.valid = 1'b1;
    ycbcr_if.data  = d;
    pend0 = e0;
    pend1 = e1;
    in_f  = 1'b0;
    for (int t = 0; t < 20 && !in_f; t++) tick();
    if (!in_f) chk("send_timeout", 96'(in_f), 96'(1));
    ycbcr_if.valid = 1'b0;
  endtask

  function automatic logic [95:0] rand_beat();
    logic [95:0] d;
    for (int i = 0; i < 3; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic send_rand();
    logic [95:0] d;
    d = rand_beat();
    send(d, model_pair(d[23:0], d[47:24]), model_pair(d[71:48], d[95:72]));
  endtask

  task automatic idle(input int n);
    ycbcr_if.valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [95:0] held;
    logic [95:0] d;
    int          n0;

    tbl[0].data = {px(13,101,201), px(12,100,200), px(11,22,31), px(10,20,30)};
    tbl[0].e0_t = pw(10,21,11,30);    tbl[0].e1_t = pw(12,100,13,200);
    tbl[0].e0_r = pw(10,21,11,31);    tbl[0].e1_r = pw(12,101,13,201);
    tbl[1].data = {px(0,1,1), px(0,0,0), px(255,255,255), px(255,255,255)};
    tbl[1].e0_t = pw(255,255,255,255); tbl[1].e1_t = pw(0,0,0,0);
    tbl[1].e0_r = pw(255,255,255,255); tbl[1].e1_r = pw(0,1,0,1);
    tbl[2].data = {px(200,255,0), px(100,0,255), px(2,255,4), px(1,254,3)};
    tbl[2].e0_t = pw(1,254,2,3);      tbl[2].e1_t = pw(100,127,200,127);
    tbl[2].e0_r = pw(1,255,2,4);      tbl[2].e1_r = pw(100,128,200,128);
    tbl[3].data = {px(127,127,127), px(128,128,128), px(70,80,90), px(7,8,9)};
    tbl[3].e0_t = pw(7,44,70,49);     tbl[3].e1_t = pw(128,127,127,127);
    tbl[3].e0_r = pw(7,44,70,50);     tbl[3].e1_r = pw(128,128,127,128);

    ycbcr_if.valid = 1'b0;
    ycbcr_if.data  = '0;
    ycbcr_if.strb  = '0;
    yuyv_if.ready  = 1'b0;

    // Reset state
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_valid", 96'(yuyv_if.valid), 96'(0));
    chk("rst_ready", 96'(ycbcr_if.ready), 96'(1));
    chk("rst_data", yuyv_if.data, 96'(0));
    chk("strb", 96'(yuyv_if.strb), 96'(12'hfff));
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Table vectors: count walks 0->2->4->3->2
    yuyv_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (RND == 1) send(tbl[i].data, tbl[i].e0_r, tbl[i].e1_r);
      else          send(tbl[i].data, tbl[i].e0_t, tbl[i].e1_t);
      if (i == 0) chk("one_beat_no_valid", 96'(yuyv_if.valid), 96'(0));
      if (i == 1) begin
        chk("first_pair", 96'(yuyv_if.data[31:0]), 96'(RND == 1 ? tbl[0].e0_r : tbl[0].e0_t));
        chk("second_pair_cb", 96'(yuyv_if.data[47:40]), 96'(RND == 1 ? 101 : 100));
      end
    end
    idle(2);
    chk("tbl_out_beats", 96'(n_out), 96'(2));

    // Streaming: 30 back-to-back beats
    do_clear();
    n0 = n_out;
    stream_phase = 1'b1;
    for (int i = 0; i < 30; i++) send_rand();
    stream_phase = 1'b0;
    idle(3);
    chk("stream_beats", 96'(n_out - n0), 96'(20));
    chk("stream_ready_drops", 96'(rdy_drop), 96'(0));

    // Backpressure: downstream stalls with input pending
    do_clear();
    yuyv_if.ready = 1'b0;
    send_rand();
    send_rand();
    held = yuyv_if.data;
    d = rand_beat();
    ycbcr_if.valid = 1'b1;
    ycbcr_if.data  = d;
    pend0 = model_pair(d[23:0], d[47:24]);
    pend1 = model_pair(d[71:48], d[95:72]);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_in_stall", 96'(in_f), 96'(0));
      chk("bp_hold_data", yuyv_if.data, held);
      chk("bp_hold_valid", 96'(yuyv_if.valid), 96'(1));
    end
    yuyv_if.ready = 1'b1;
    send(d, pend0, pend1);
    for (int i = 0; i < 4; i++) send_rand();
    idle(3);

    // Clear at count 4 together with an input handshake
    yuyv_if.ready = 1'b0;
    do_clear();
    send_rand();
    send_rand();
    yuyv_if.ready = 1'b1;
    clear_i = 1'b1;
    ycbcr_if.valid = 1'b1;
    ycbcr_if.data  = rand_beat();
    tick();
    clear_i = 1'b0;
    ycbcr_if.valid = 1'b0;
    chk("clr_valid", 96'(yuyv_if.valid), 96'(0));
    n0 = n_out;
    send_rand();
    chk("clr_one_beat_valid", 96'(yuyv_if.valid), 96'(0));
    send_rand();
    idle(2);
    chk("clr_post_beats", 96'(n_out - n0), 96'(1));

    // Asynchronous reset at count 3
    yuyv_if.ready = 1'b0;
    do_clear();
    send_rand();
    send_rand();
    yuyv_if.ready = 1'b1;
    send_rand();
    chk("pre_rst_valid", 96'(yuyv_if.valid), 96'(1));
    yuyv_if.ready = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", 96'(yuyv_if.valid), 96'(0));
    chk("async_rst_ready", 96'(ycbcr_if.ready), 96'(1));
    chk("async_rst_data", yuyv_if.data, 96'(0));
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    yuyv_if.ready = 1'b1;
    n0 = n_out;
    send_rand();
    send_rand();
    idle(2);
    chk("post_rst_beats", 96'(n_out - n0), 96'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
